// File: rtl/image_loader.sv
// Pixel stream input stage: quantises 8-bit grayscale pixels and packs them into
// a flattened frame vector that is held, with data_valid, until acknowledged.
module image_loader #(
  parameter int INPUT_DATA_SIZE = 784,
  parameter int RESOLUTION      = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [7:0]                            pix_in,
  input  logic                                  pix_valid,
  input  logic                                  pix_sof,
  output logic                                  pix_ready,
  output logic [RESOLUTION*INPUT_DATA_SIZE-1:0] data_out,
  output logic                                  data_valid,
  input  logic                                  data_ack,
  output logic                                  sof_err,
  output logic [7:0]                            frame_cnt
);

  localparam int IDX_W = $clog2(INPUT_DATA_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_DATA_SIZE - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t                        state, state_next;
  logic [IDX_W-1:0]              idx, idx_next, wr_idx;
  logic                          wr_en, restart, done;
  logic signed [RESOLUTION-1:0]  elem;

  // Top RESOLUTION-1 bits of the pixel under a zero sign bit: always non-negative.
  function automatic logic signed [RESOLUTION-1:0] quantise(input logic [7:0] pix);
    return $signed({1'b0, pix[7 -: RESOLUTION-1]});
  endfunction

  assign elem       = quantise(pix_in);
  assign pix_ready  = (state == FILL);
  assign data_valid = (state == FULL);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    wr_idx     = idx;
    wr_en      = 1'b0;
    restart    = 1'b0;
    done       = 1'b0;
    case (state)
      FILL: begin
        if (pix_valid) begin
          wr_en = 1'b1;
          // A mid-frame SOF restarts the frame, even on what would be the last pixel.
          if (pix_sof && (idx != '0)) begin
            restart  = 1'b1;
            wr_idx   = '0;
            idx_next = IDX_W'(1);
          end else if (idx == LAST_IDX) begin
            done       = 1'b1;
            idx_next   = '0;
            state_next = FULL;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      FULL: begin
        if (data_ack) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sof_err   <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      sof_err <= restart;
      if (done) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (wr_en) begin
      data_out[int'(wr_idx)*RESOLUTION +: RESOLUTION] <= elem;
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: a full-size instance (N=784) and a small one (N=4),
// expected frames queued as stimulus is driven and compared at frame completion.
module tb_image_loader;

  localparam int N  = 784;
  localparam int R  = 8;
  localparam int W  = N * R;
  localparam int N4 = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0, reset4 = 1'b0;
  logic [7:0]   pix_in = '0, pix_in4 = '0;
  logic         pix_valid = 1'b0, pix_sof = 1'b0, data_ack = 1'b0;
  logic         pix_valid4 = 1'b0, pix_sof4 = 1'b0, data_ack4 = 1'b0;
  logic         pix_ready, data_valid, sof_err;
  logic         pix_ready4, data_valid4, sof_err4;
  logic [W-1:0] data_out;
  logic [31:0]  data_out4;
  logic [7:0]   frame_cnt, frame_cnt4;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  big_q[$];
  logic [31:0]   small_q[$];
  logic [7:0]    pix_buf[N];
  logic [W-1:0]  last_big;

  always #5 clk = ~clk;

  image_loader #(.INPUT_DATA_SIZE(N), .RESOLUTION(R)) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .data_out(data_out),
    .data_valid(data_valid), .data_ack(data_ack), .sof_err(sof_err),
    .frame_cnt(frame_cnt)
  );

  image_loader #(.INPUT_DATA_SIZE(N4), .RESOLUTION(R)) dut4 (
    .clk(clk), .reset(reset4), .pix_in(pix_in4), .pix_valid(pix_valid4),
    .pix_sof(pix_sof4), .pix_ready(pix_ready4), .data_out(data_out4),
    .data_valid(data_valid4), .data_ack(data_ack4), .sof_err(sof_err4),
    .frame_cnt(frame_cnt4)
  );

  function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < N; i++)
      if (a[i*R +: R] !== b[i*R +: R]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives pix_buf as one back-to-back frame into the large instance.
  task automatic send_big(input bit sof_first);
    for (int i = 0; i < N; i++) begin
      pix_in    = pix_buf[i];
      pix_valid = 1'b1;
      pix_sof   = sof_first && (i == 0);
      tick();
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset4 = 1'b1;
    tick(); tick();
    reset = 1'b0; reset4 = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || pix_ready !== 1'b1) begin
      errors++; $display("FAIL reset_handshake: valid=%b ready=%b, want 0/1", data_valid, pix_ready);
    end
    checks++;
    if (frame_cnt !== 8'd0 || sof_err !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: cnt=%0d sof_err=%b, want 0/0", frame_cnt, sof_err);
    end
    checks++;
    if (data_out !== '0) begin
      errors++; $display("FAIL reset_data: element %0d nonzero, want all 0", first_diff(data_out, '0));
    end
    checks++;
    if (data_out4 !== 32'd0 || data_valid4 !== 1'b0 || pix_ready4 !== 1'b1) begin
      errors++; $display("FAIL reset_small: data=%h valid=%b ready=%b, want 0/0/1", data_out4, data_valid4, pix_ready4);
    end
  endtask

  task automatic test_ramp();
    logic [W-1:0] exp_v, got_v;
    for (int i = 0; i < N; i++) begin
      pix_buf[i] = 8'(i % 256);
      exp_v[i*R +: R] = pix_buf[i] >> 1;
    end
    big_q.push_back(exp_v);
    for (int i = 0; i < N; i++) begin
      pix_in = pix_buf[i]; pix_valid = 1'b1; pix_sof = (i == 0);
      tick();
      if (i == N - 2) begin
        checks++;
        if (data_valid !== 1'b0) begin
          errors++; $display("FAIL ramp_early_valid: valid=%b before last pixel, want 0", data_valid);
        end
      end
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    checks++;
    if (data_valid !== 1'b1 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL ramp_latency: valid=%b ready=%b, want 1/0", data_valid, pix_ready);
    end
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL ramp_cnt: cnt=%0d, want 1", frame_cnt);
    end
    got_v = big_q.pop_front();
    last_big = got_v;
    checks++;
    if (data_out !== got_v) begin
      errors++; $display("FAIL ramp_frame: first bad element %0d", first_diff(data_out, got_v));
    end
    checks++;
    if (data_out[1*R +: R] !== 8'd0 || data_out[255*R +: R] !== 8'd127 || data_out[783*R +: R] !== 8'd7) begin
      errors++; $display("FAIL ramp_elements: e1=%0d e255=%0d e783=%0d, want 0/127/7",
                         data_out[1*R +: R], data_out[255*R +: R], data_out[783*R +: R]);
    end
  endtask

  task automatic test_backpressure();
    int bad_ready = 0, bad_data = 0;
    pix_in = 8'd255; pix_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (pix_ready !== 1'b0 || data_valid !== 1'b1) bad_ready++;
      if (data_out !== last_big) bad_data++;
    end
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL bp_ready: %0d cycles not held FULL, want 0", bad_ready);
    end
    checks++;
    if (bad_data != 0) begin
      errors++; $display("FAIL bp_frozen: %0d cycles data changed, want 0", bad_data);
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    checks++;
    if (pix_ready !== 1'b1 || data_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: ready=%b valid=%b, want 1/0", pix_ready, data_valid);
    end
    tick();
    pix_valid = 1'b0;
    checks++;
    if (data_out[0 +: R] !== 8'd127 || data_out[R +: R] !== last_big[R +: R]) begin
      errors++; $display("FAIL bp_next_idx0: e0=%0d e1=%0d, want 127/%0d",
                         data_out[0 +: R], data_out[R +: R], last_big[R +: R]);
    end
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL bp_cnt: cnt=%0d, want 1", frame_cnt);
    end
  endtask

  task automatic test_sof_restart();
    logic [W-1:0] exp_v, got_v;
    int pulses = 0, early_valid = 0;
    for (int i = 0; i < N; i++) exp_v[i*R +: R] = 8'd25;
    big_q.push_back(exp_v);
    pix_in = 8'd200; pix_valid = 1'b1; pix_sof = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sof_err === 1'b1) pulses++;
      if (data_valid !== 1'b0) early_valid++;
    end
    pix_in = 8'd50; pix_sof = 1'b1;
    tick();
    pix_sof = 1'b0;
    checks++;
    if (sof_err !== 1'b1) begin
      errors++; $display("FAIL sof_pulse: sof_err=%b after restart edge, want 1", sof_err);
    end
    if (sof_err === 1'b1) pulses++;
    for (int i = 0; i < N - 1; i++) begin
      tick();
      if (sof_err === 1'b1) pulses++;
      if (i < N - 2 && data_valid !== 1'b0) early_valid++;
    end
    pix_valid = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL sof_count: %0d pulses, want 1", pulses);
    end
    checks++;
    if (early_valid != 0 || data_valid !== 1'b1 || frame_cnt !== 8'd2) begin
      errors++; $display("FAIL sof_one_frame: early=%0d valid=%b cnt=%0d, want 0/1/2",
                         early_valid, data_valid, frame_cnt);
    end
    got_v = big_q.pop_front();
    checks++;
    if (data_out !== got_v) begin
      errors++; $display("FAIL sof_frame: first bad element %0d", first_diff(data_out, got_v));
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_v, got_v;
    for (int i = 0; i < 300; i++) begin
      pix_in = 8'((i * 7) % 256); pix_valid = 1'b1; pix_sof = (i == 0);
      tick();
    end
    reset = 1'b1; pix_in = 8'd99; pix_sof = 1'b1;
    tick();
    reset = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    checks++;
    if (data_out !== '0 || data_valid !== 1'b0 || pix_ready !== 1'b1 || frame_cnt !== 8'd0 || sof_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid: bad_elem=%0d valid=%b ready=%b cnt=%0d sof=%b, want -1/0/1/0/0",
                         first_diff(data_out, '0), data_valid, pix_ready, frame_cnt, sof_err);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) begin
        pix_buf[i] = 8'((i * (3 + 2 * pass) + 1 + pass) % 256);
        exp_v[i*R +: R] = pix_buf[i] >> 1;
      end
      big_q.push_back(exp_v);
      send_big(1'b0);
      got_v = big_q.pop_front();
      checks++;
      if (data_valid !== 1'b1 || frame_cnt !== 8'd1 || data_out !== got_v) begin
        errors++; $display("FAIL rst_refill%0d: valid=%b cnt=%0d first bad element %0d, want 1/1/-1",
                           pass, data_valid, frame_cnt, first_diff(data_out, got_v));
      end
      if (pass == 0) begin
        reset = 1'b1; data_ack = 1'b1;
        tick();
        reset = 1'b0; data_ack = 1'b0;
        checks++;
        if (data_out !== '0 || data_valid !== 1'b0 || pix_ready !== 1'b1 || frame_cnt !== 8'd0) begin
          errors++; $display("FAIL rst_full: bad_elem=%0d valid=%b ready=%b cnt=%0d, want -1/0/1/0",
                             first_diff(data_out, '0), data_valid, pix_ready, frame_cnt);
        end
      end
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic test_bubbles();
    logic [31:0] got;
    small_q.push_back({8'd4, 8'd3, 8'd2, 8'd1});
    for (int k = 0; k < 4; k++) begin
      pix_in4 = 8'(2 * (k + 1)); pix_valid4 = 1'b1; pix_sof4 = (k == 0);
      tick();
      pix_valid4 = 1'b0; pix_sof4 = 1'b0;
      if (k < 3) begin
        tick();
        checks++;
        if (data_valid4 !== 1'b0) begin
          errors++; $display("FAIL bubble_early: valid=%b after accept %0d, want 0", data_valid4, k + 1);
        end
      end
    end
    got = small_q.pop_front();
    checks++;
    if (data_valid4 !== 1'b1 || data_out4 !== got) begin
      errors++; $display("FAIL bubble_frame: valid=%b data=%h, want 1/%h", data_valid4, data_out4, got);
    end
    data_ack4 = 1'b1;
    tick();
    data_ack4 = 1'b0;
  endtask

  task automatic test_wrap_stray_ack();
    logic [31:0] exp_v, got;
    logic [7:0]  cnt_model = 8'd0;
    int bad_stray = 0, bad_frame = 0, bad_cnt = 0;
    reset4 = 1'b1;
    tick();
    reset4 = 1'b0;
    for (int f = 0; f < 257; f++) begin
      for (int j = 0; j < N4; j++) begin
        pix_in4 = 8'($urandom_range(0, 255));
        exp_v[j*8 +: 8] = pix_in4 >> 1;
        if (j == N4 - 1) small_q.push_back(exp_v);
        pix_valid4 = 1'b1; data_ack4 = (j == 1);
        tick();
        data_ack4 = 1'b0;
        if (j == 1 && (data_valid4 !== 1'b0 || pix_ready4 !== 1'b1)) bad_stray++;
      end
      pix_valid4 = 1'b0;
      cnt_model = cnt_model + 8'd1;
      got = small_q.pop_front();
      if (data_valid4 !== 1'b1 || data_out4 !== got) bad_frame++;
      if (frame_cnt4 !== cnt_model) bad_cnt++;
      data_ack4 = 1'b1;
      tick();
      data_ack4 = 1'b0;
    end
    checks++;
    if (bad_stray != 0) begin
      errors++; $display("FAIL stray_ack: %0d frames disturbed, want 0", bad_stray);
    end
    checks++;
    if (bad_frame != 0) begin
      errors++; $display("FAIL wrap_frames: %0d bad frames, want 0", bad_frame);
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++; $display("FAIL wrap_cnt_track: %0d frame_cnt deviations, want 0", bad_cnt);
    end
    checks++;
    if (frame_cnt4 !== 8'd1) begin
      errors++; $display("FAIL wrap_cnt: cnt=%0d after 257 frames, want 1", frame_cnt4);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_sof_restart();
    test_reset_mid();
    test_bubbles();
    test_wrap_stray_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
# image_loader

Input stage in front of the hidden-layer neurons. It accepts a serial stream of 8-bit unsigned grayscale pixels through a valid/ready handshake. Each pixel is quantised to a signed RESOLUTION-bit fixed-point value and packed into the flattened input vector that every neuron reads. The vector is held stable, with data_valid asserted, until the consumer acknowledges it, so the neuron array always sees a complete frame and never a partial one.

## Interface
- INPUT_DATA_SIZE, 784: pixels per frame (N); legal range is 2 or more.
- RESOLUTION, 8: bits per packed element; legal range is 2..8.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  reset, synchronous, active-high.
- pix_in  in  8  unsigned pixel value.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_sof  in  1  start-of-frame marker; qualified by pix_valid.
- pix_ready  out  1  block can accept a pixel this cycle.
- data_out  out  RESOLUTION*INPUT_DATA_SIZE  flattened signed frame vector.
- data_valid  out  1  data_out holds a complete frame.
- data_ack  in  1  consumer has taken the frame; qualified by data_valid.
- sof_err  out  1  one-cycle pulse when a frame is restarted by pix_sof.
- frame_cnt  out  8  count of completed frames; wraps from 255 to 0.

## Operation
- **Accept:** a pixel is accepted on a clock edge where pix_valid && pix_ready is true.
- **Quantise:** element = {1'b0, pix_in[7:9-RESOLUTION]}.
  - The element is always non-negative.
  - RESOLUTION=8 gives the range 0..127.
- **Pack:** pixel index i (0 is the first pixel of the frame) is written to data_out[(i+1)*RESOLUTION-1 -: RESOLUTION].
- **Index counter idx:** range 0..N-1.
- **State machine:** two states, FILL and FULL.
- **FILL** (pix_ready=1, data_valid=0):
  - On an accepted pixel with idx < N-1: store the element at idx, then idx <= idx+1.
  - On an accepted pixel with idx == N-1: store the element, idx <= 0, go to FULL, frame_cnt <= frame_cnt+1.
  - On an accepted pixel with pix_sof=1 and idx != 0: discard the partial frame, store the element at index 0, idx <= 1, and pulse sof_err for one cycle.
  - pix_sof at idx == 0 is normal.
  - pix_sof is advisory: a frame may start without it.
  - Special case N-1 == idx with pix_sof=1 and idx != 0: the restart rule takes priority and no frame completes.
- **FULL** (pix_ready=0, data_valid=1):
  - data_out is frozen.
  - pix_valid and pix_sof are ignored.
  - When data_ack=1, go to FILL.
- data_ack outside FULL is ignored.
- After an ack, data_out keeps the old frame's contents. Those bits are overwritten element by element as the new frame fills.
- **Reset** (at any time, including mid-frame or while FULL):
  - state <= FILL, idx <= 0, data_out <= 0.
  - data_valid = 0, pix_ready = 1 (combinational from state FILL).
  - sof_err <= 0, frame_cnt <= 0.
- pix_ready and data_valid are decoded directly from the state register, with no combinational path from any input.
- sof_err is registered.

## Timing
- Accept throughput is one pixel per cycle while in FILL; gaps in pix_valid are allowed.
- **Frame completion latency:** if the last pixel is accepted at edge k, then data_valid=1, pix_ready=0 and the new frame_cnt value are all visible in the cycle after edge k.
- **Ack release:** if data_ack is seen at edge m while FULL, then data_valid=0 and pix_ready=1 from the cycle after edge m. The first pixel of the next frame can therefore be accepted at edge m+1.
- The minimum frame period is N+1 cycles when the consumer acks in the first FULL cycle.
- **sof_err:** high for exactly the one cycle following the restarting edge.
- **Reset precedence:** reset wins over every simultaneous event (accept, ack, sof).

## Test plan
- **Full frame, ramp:** reset, then 784 consecutive pixels with p_i = i mod 256 and pix_sof on pixel 0.
  - data_valid rises the cycle after pixel 783 is accepted.
  - Element i equals (i mod 256)>>1; element 1 = 0, element 255 = 127, element 783 = 7.
  - frame_cnt = 1.
- **Backpressure:** hold data_ack=0 for 20 cycles after the frame completes while driving pix_valid=1 with p=255.
  - pix_ready stays 0 and data_out is unchanged.
  - After ack, pix_ready=1 on the next cycle and the next frame begins at index 0.
- **SOF restart:** send 100 pixels of value 200, then pixel value 50 with pix_sof=1, then 783 more pixels of value 50.
  - sof_err pulses once.
  - Exactly one frame completes, with every element = 25.
- **Bubbles:** a frame with pix_valid toggling 1/0 (N=4 build, pixels 2,4,6,8 at RESOLUTION=8).
  - data_valid appears after the 4th accept.
  - data_out = {8'd4, 8'd3, 8'd2, 8'd1}.
- **Reset mid-operation:** assert reset after 300 pixels, and separately while FULL.
  - Next cycle: data_out=0, data_valid=0, pix_ready=1, frame_cnt=0, idx=0.
  - A following full frame packs correctly.
- **Wrap and stray ack:** N=4 build, run 257 frames, and pulse data_ack during FILL.
  - Stray acks have no effect.
  - frame_cnt reads 1 after the 257th frame.
